mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 4-input datapath resource among four
//   requesters, e.g. the shared memory/ALU operand path in the multi-cycle
//   RISC-V core. It drives the 2-bit select of a 4:1 mux (mux4) and a one-hot
//   grant, and holds both stable until the resource signals completion.
//   It sits between the requester units and the mux4 + resource pair.
// PARAMETERS
//   TIMEOUT_CYCLES  16  max cycles a grant is held without done (ARB_TIMEOUT_EN only)
// PORTS
//   clk       in   1   rising-edge clock
//   resetn    in   1   asynchronous, active-low reset
//   req       in   4   request per requester; bit i -> mux input d<i>
//   done      in   1   resource finished the current transaction (1-cycle pulse)
//   sel       out  2   mux4 select (00=d0 .. 11=d3), registered
//   gnt       out  4   one-hot grant, registered; 0 when idle
//   gnt_valid out  1   a grant is active (== |gnt)
//   timeout   out  1   1-cycle pulse on forced release (0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//   - Reset (resetn=0, async): state=IDLE, sel=2'b00, gnt=4'b0000,
//     gnt_valid=0, timeout=0, priority pointer ptr=2'd0, timeout counter=0.
//   - States: IDLE (no grant), BUSY (grant held).
//   - Arbitration: search req starting at index ptr, ascending, wrap 3->0;
//     first set bit k wins. Result registered: sel=k, gnt=1<<k, gnt_valid=1
//     on the next rising edge (1-cycle latency from req to grant).
//   - IDLE: req==0 -> stay IDLE, outputs hold (sel keeps last granted value).
//     req!=0 -> arbitrate, go BUSY.
//   - BUSY: sel/gnt frozen; req changes ignored (dropping req does not
//     release). done=1 -> ptr=(sel+1) mod 4; if req has any bit set, arbitrate
//     from the NEW ptr in the same cycle and stay BUSY (back-to-back, no idle
//     bubble); else gnt=0, gnt_valid=0, go IDLE, sel holds.
//   - done while IDLE is ignored (no state or pointer change).
//   - Fairness: a continuously requesting input is granted within 4 grants.
//   - Reset mid-transaction drops the grant immediately (async); resource
//     side must tolerate abandonment.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined: counter cnt, width $clog2(TIMEOUT_CYCLES+1),
//     cleared on every new grant, increments each BUSY cycle without done.
//     When cnt reaches TIMEOUT_CYCLES-1 and done=0, force release exactly as
//     a done (pointer advance, back-to-back arbitration allowed) and pulse
//     timeout=1 for one cycle. done in the same cycle wins: no timeout pulse.
//   ARB_TIMEOUT_EN undefined: no counter; grant held indefinitely until done;
//     timeout tied to 1'b0.
// TESTING
//   1. Reset: resetn=0 with req=4'b1111 -> sel=00, gnt=0000, gnt_valid=0, timeout=0.
//   2. Single request: req=4'b0100 -> next edge sel=10, gnt=0100; done pulse
//      with req=0 -> next edge gnt=0000, gnt_valid=0, sel stays 10.
//   3. Round robin: req=4'b1111 held, done every 3rd cycle -> sel sequence
//      00,01,10,11,00 with no idle cycle between grants.
//   4. Pointer wrap/skip: after grant to 3, req=4'b0110 -> grant 1 then 2.
//   5. Hold: granted requester 0 drops req, done withheld 10 cycles -> gnt
//      stays 0001; done with req=4'b1000 -> gnt=1000 next edge.
//   6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: grant 2, no done -> forced release
//      16 cycles after grant, timeout high one cycle; done on cycle 16 instead
//      -> normal release, timeout stays 0. Without macro: grant held 100 cycles.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant bundle between requesters, mux4 select and the shared resource.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;
  modport master (output req, done, input sel, gnt, gnt_valid, timeout);
  modport slave  (input req, done, output sel, gnt, gnt_valid, timeout);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter driving a mux4 select and one-hot grant, held until done.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT_CYCLES busy cycles without done.
module mux4_rr_arbiter
`ifdef ARB_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 16)
`endif
(
  input logic              clk,
  input logic              resetn,
  mux4_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state;
  logic [1:0] ptr, sel, base, win;
  logic [3:0] gnt;
  logic       gnt_valid, timeout, expire, rel, any, grant_new;
  assign any       = |bus.req;
  assign rel       = state == BUSY && (bus.done || expire);
  assign grant_new = (state == IDLE || rel) && any;
  // on release the search starts from the pointer being written this cycle
  assign base      = state == BUSY ? sel + 2'd1 : ptr;
  always_comb begin
    win = base;
    for (int i = 3; i >= 0; i--)
      if (bus.req[base + 2'(i)]) win = base + 2'(i);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      sel       <= 2'd0;
      gnt       <= 4'd0;
      gnt_valid <= 1'b0;
      ptr       <= 2'd0;
    end else begin
      if (rel) ptr <= sel + 2'd1;
      if (grant_new) begin
        sel       <= win;
        gnt       <= 4'b1 << win;
        gnt_valid <= 1'b1;
        state     <= BUSY;
      end else if (rel) begin
        gnt       <= 4'd0;
        gnt_valid <= 1'b0;
        state     <= IDLE;
      end
    end
  end
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expire = !bus.done && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= rel && !bus.done;
      cnt     <= grant_new ? '0 : (state == BUSY && !bus.done) ? cnt + CW'(1) : cnt;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif
  assign bus.sel       = sel;
  assign bus.gnt       = gnt;
  assign bus.gnt_valid = gnt_valid;
  assign bus.timeout   = timeout;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed checks of reset, grant latency, round robin, hold and release limits.
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  mux4_rr_arbiter_if bus ();
  mux4_rr_arbiter dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [1:0] s, input logic [3:0] g, input logic v, input logic t);
    chk({tag, ".sel"}, {2'b00, bus.sel}, {2'b00, s});
    chk({tag, ".gnt"}, bus.gnt, g);
    chk({tag, ".gnt_valid"}, {3'b000, bus.gnt_valid}, {3'b000, v});
    chk({tag, ".timeout"}, {3'b000, bus.timeout}, {3'b000, t});
  endtask
  initial begin
    bus.req  = 4'b1111;
    bus.done = 1'b0;
    step(3);
    chk_all("reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    bus.req = 4'b0000;
    resetn  = 1'b1;
    step();
    chk_all("idle_after_reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    bus.req = 4'b0100;
    step();
    chk_all("single_grant", 2'd2, 4'b0100, 1'b1, 1'b0);
    bus.req  = 4'b0000;
    bus.done = 1'b1;
    step();
    chk_all("single_release", 2'd2, 4'b0000, 1'b0, 1'b0);
    step();
    chk_all("done_in_idle", 2'd2, 4'b0000, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0001;
    step();
    chk_all("ptr_after_idle_done", 2'd0, 4'b0001, 1'b1, 1'b0);
    resetn = 1'b0;
    #1;
    chk_all("async_reset_drop", 2'd0, 4'b0000, 1'b0, 1'b0);
    bus.req = 4'b1111;
    resetn  = 1'b1;
    step();
    chk_all("rr0", 2'd0, 4'b0001, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_all("rr_hold", 2'(k - 1), 4'b1 << (k - 1), 1'b1, 1'b0);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk_all("rr_next", 2'(k % 4), 4'b1 << (k % 4), 1'b1, 1'b0);
    end
    step();
    bus.req  = 4'b1000;
    bus.done = 1'b1;
    step();
    chk_all("grant3", 2'd3, 4'b1000, 1'b1, 1'b0);
    bus.req = 4'b0110;
    step();
    chk_all("wrap_to1", 2'd1, 4'b0010, 1'b1, 1'b0);
    step();
    chk_all("skip_to2", 2'd2, 4'b0100, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step();
    bus.done = 1'b0;
    chk_all("back_to_idle", 2'd2, 4'b0000, 1'b0, 1'b0);
    bus.req = 4'b0001;
    step();
    chk_all("hold_grant0", 2'd0, 4'b0001, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step(10);
    chk_all("hold_10", 2'd0, 4'b0001, 1'b1, 1'b0);
    bus.req  = 4'b1000;
    bus.done = 1'b1;
    step();
    chk_all("hold_handoff", 2'd3, 4'b1000, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step();
    bus.done = 1'b0;
    chk_all("hold_release", 2'd3, 4'b0000, 1'b0, 1'b0);
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    chk_all("to_grant", 2'd2, 4'b0100, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    step(15);
    chk_all("to_before", 2'd2, 4'b0100, 1'b1, 1'b0);
    step();
    chk_all("to_forced", 2'd2, 4'b0000, 1'b0, 1'b1);
    step();
    chk_all("to_pulse_end", 2'd2, 4'b0000, 1'b0, 1'b0);
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    chk_all("to_grant2", 2'd2, 4'b0100, 1'b1, 1'b0);
    step(15);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk_all("to_done_wins", 2'd2, 4'b0000, 1'b0, 1'b0);
`else
    step(100);
    chk_all("no_to_hold100", 2'd2, 4'b0100, 1'b1, 1'b0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk_all("no_to_release", 2'd2, 4'b0000, 1'b0, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
